mips_instr_encoder: RTL and testbench
=====================================

# mips_instr_encoder

Instruction-memory loader and encoder for the single-cycle MIPS core: the encode direction of the main control decoder. It accepts symbolic instruction requests (operation class plus register and immediate fields) over a valid/ready handshake, packs each into a 32-bit MIPS word, and writes the words to consecutive instruction-memory locations. The testbench and boot logic use it to fill instruction memory before the core is released.

## Interface

- IM_DEPTH, 1024: instruction-memory capacity in words.
- ADDR_W, 10: word-address width; IM_DEPTH ≤ 2^ADDR_W.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load session at word 0.
- in_valid  in  1  request present.
- in_ready  out  1  encoder can accept a request this cycle.
- in_op  in  4  operation class: 0 addu, 1 subu, 2 ori, 3 lw, 4 sw, 5 beq, 6 lui, 7 j, 8 jal, 9 jr; 10–15 are illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  26  immediate; bits [15:0] for I-type, all 26 bits for j/jal.
- in_last  in  1  marks the final request of the session.
- im_we  out  1  instruction-memory write strobe.
- im_addr  out  ADDR_W  word address.
- im_wdata  out  32  encoded instruction.
- word_cnt  out  ADDR_W+1  words written this session.
- busy  out  1  FSM is in LOAD or DRAIN.
- done  out  1  session complete.
- err  out  1  sticky; at least one illegal op was seen this session.

## Operation

- FSM states: IDLE, LOAD, DRAIN, DONE. Reset enters IDLE.
- IDLE or DONE with start=1 goes to LOAD. This clears the write pointer, word_cnt, the accepted count and err.
- start is ignored in LOAD and DRAIN.
- in_ready = (state==LOAD) && (accepted < IM_DEPTH). A request is accepted when in_valid && in_ready.
- An accepted legal request is registered into a one-entry write stage.
- An accepted illegal op is dropped: no write, accepted count unchanged, err set.
- LOAD goes to DRAIN on an accepted request with in_last=1, or when accepted reaches IM_DEPTH.
- DRAIN goes to DONE once the write stage is empty.
- DONE holds done=1 until the next start.
- Encoding (opcode, then fields, then funct):
  - addu: 000000, rs, rt, rd, 00000, 100001
  - subu: same layout as addu, funct 100011
  - ori: 001101, rs, rt, imm[15:0]
  - lw: 100011, rs, rt, imm[15:0]
  - sw: 101011, rs, rt, imm[15:0]
  - beq: 000100, rs, rt, imm[15:0]
  - lui: 001111, 00000, rt, imm[15:0]
  - j: 000010, imm[25:0]
  - jal: 000011, imm[25:0]
  - jr: 000000, rs, 15'b0, 001000
- Fields not used by an op are ignored; they never leak into the encoded word.
- An illegal op with in_last=1 still ends the session.
- The write pointer is not allowed to wrap. Capacity exhaustion forces DRAIN; requests beyond IM_DEPTH are never accepted.

## Timing

- Reset values: in_ready=0, im_we=0, im_addr=0, im_wdata=0, word_cnt=0, busy=0, done=0, err=0, state IDLE.
- Asserting rst_n low at any time, including mid-session, clears all state and outputs immediately. A pending write is lost.
- start captured at edge N puts the FSM in LOAD, so in_ready=1 in cycle N+1.
- start together with in_valid in IDLE: the request is not accepted.
- Latency: a request accepted at edge K gives im_we=1 with its address and data during cycle K+1. word_cnt increments at edge K+2.
- Throughput is one word per cycle with no bubbles; im_addr increments by 1 per write.
- im_we is high for exactly one cycle per legal accepted request.
- For an in_last request accepted at edge K: DRAIN during K+1, done=1 from K+2 onward.
- Full boundary: the IM_DEPTH-th acceptance drops in_ready in the next cycle, and the last write goes to address IM_DEPTH-1.

## Test plan

- addu with rs=1, rt=2, rd=3 -> im_wdata=0x00221821 at address 0, one cycle after acceptance.
- Sequence ori(rs=0, rt=8, imm=0x1234), lui(rt=9, imm=0xABCD), j(imm=0x0000C00), jr(rs=31), with in_last on jr -> words 0x34081234, 0x3C09ABCD, 0x08000C00, 0x03E00008 at addresses 0–3; word_cnt=4; done=1.
- Continuous in_valid with in_last never set, IM_DEPTH=4 -> exactly 4 writes (addresses 0–3); in_ready low afterward; done=1.
- in_op=12 between two legal ops -> only 2 writes, at consecutive addresses 0 and 1; err=1; err cleared by the next start.
- rst_n pulled low in the cycle im_we=1 -> im_we=0 immediately; all outputs at reset values; the next start resumes at address 0.
- start asserted while busy -> ignored; addresses keep incrementing with no restart.

Source files
------------

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: packs symbolic MIPS instruction requests into 32-bit
// words and streams them into consecutive instruction-memory locations.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | after reset; waiting for start
// LOAD   | accepting requests, one write issued per legal request
// DRAIN  | session ended; the last pending write retires
// DONE   | session complete, done held until the next start
module mips_instr_encoder #(
    parameter int IM_DEPTH = 1024,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [25:0]       in_imm,
    input  logic              in_last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [ADDR_W:0]   word_cnt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(IM_DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   acc_cnt_q, acc_cnt_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              op_legal;
    logic [31:0]       enc_word;
    logic              accept;

    // Only accepted legal requests consume an address, so the accepted count
    // doubles as the write pointer and can never run past IM_DEPTH-1.
    assign in_ready = (state_q == S_LOAD) && (acc_cnt_q < DEPTH_C);
    assign accept   = in_valid && in_ready;

    // Encode the request; unused fields are never routed into the word.
    always_comb begin
        enc_word = 32'h0;
        op_legal = 1'b1;
        case (in_op)
            4'd0:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100001};
            4'd1:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100011};
            4'd2:    enc_word = {6'b001101, in_rs, in_rt, in_imm[15:0]};
            4'd3:    enc_word = {6'b100011, in_rs, in_rt, in_imm[15:0]};
            4'd4:    enc_word = {6'b101011, in_rs, in_rt, in_imm[15:0]};
            4'd5:    enc_word = {6'b000100, in_rs, in_rt, in_imm[15:0]};
            4'd6:    enc_word = {6'b001111, 5'b00000, in_rt, in_imm[15:0]};
            4'd7:    enc_word = {6'b000010, in_imm};
            4'd8:    enc_word = {6'b000011, in_imm};
            4'd9:    enc_word = {6'b000000, in_rs, 15'b0, 6'b001000};
            default: op_legal = 1'b0;
        endcase
    end

    // Next-state and write-stage logic for the session FSM.
    always_comb begin
        state_d    = state_q;
        acc_cnt_d  = acc_cnt_q;
        err_d      = err_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        word_cnt_d = word_cnt_q + {{ADDR_W{1'b0}}, we_q};
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    acc_cnt_d  = '0;
                    word_cnt_d = '0;
                    err_d      = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (op_legal) begin
                        we_d      = 1'b1;
                        addr_d    = acc_cnt_q[ADDR_W-1:0];
                        wdata_d   = enc_word;
                        acc_cnt_d = acc_cnt_q + ONE_C;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if ((accept && in_last) || (acc_cnt_d == DEPTH_C)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Nothing new enters the write stage here, so whatever is in
                // flight retires on this edge and the stage is empty after it.
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_cnt_q  <= '0;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            acc_cnt_q  <= acc_cnt_d;
            word_cnt_q <= word_cnt_d;
            err_q      <= err_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign im_we    = we_q;
    assign im_addr  = addr_q;
    assign im_wdata = wdata_q;
    assign word_cnt = word_cnt_q;
    assign err      = err_q;
    assign busy     = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Testbench for mips_instr_encoder: directed scenarios plus randomized
// sessions checked against a cycle-level behavioural model.
module tb_mips_instr_encoder;

    localparam int DEPTH = 4;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [4:0]    in_rs, in_rt, in_rd;
    logic [25:0]   in_imm;
    logic          in_last;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic [AW:0]   word_cnt;
    logic          busy, done, err;

    mips_instr_encoder #(.IM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_imm(in_imm), .in_last(in_last), .im_we(im_we),
        .im_addr(im_addr), .im_wdata(im_wdata), .word_cnt(word_cnt),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_load, m_drain, m_done, m_err, m_we, m_accepted;
    int          m_acc, m_wc, m_addr;
    logic [31:0] m_data;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;
    wr_t wr_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_enc(input int op, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd,
                                            input logic [25:0] imm);
        logic [31:0] s, t, d, i16, i26;
        s   = 32'(rs) << 21;
        t   = 32'(rt) << 16;
        d   = 32'(rd) << 11;
        i16 = 32'(imm[15:0]);
        i26 = 32'(imm);
        case (op)
            0:       return s + t + d + 32'd33;
            1:       return s + t + d + 32'd35;
            2:       return (32'd13 << 26) + s + t + i16;
            3:       return (32'd35 << 26) + s + t + i16;
            4:       return (32'd43 << 26) + s + t + i16;
            5:       return (32'd4  << 26) + s + t + i16;
            6:       return (32'd15 << 26) + t + i16;
            7:       return (32'd2  << 26) + i26;
            8:       return (32'd3  << 26) + i26;
            9:       return s + 32'd8;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_load = 0; m_drain = 0; m_done = 0; m_err = 0; m_we = 0;
        m_accepted = 0; m_acc = 0; m_wc = 0; m_addr = 0; m_data = 32'h0;
    endtask

    task automatic check_outs();
        check("in_ready", in_ready, m_load && (m_acc < DEPTH));
        check("im_we", im_we, m_we);
        check("word_cnt", word_cnt, m_wc);
        check("busy", busy, m_load || m_drain);
        check("done", done, m_done);
        check("err", err, m_err);
        if (m_we) begin
            check("im_addr", im_addr, m_addr);
            check("im_wdata", im_wdata, m_data);
        end
    endtask

    // One clock: model reacts to the inputs present at the edge.
    task automatic cycle();
        bit acc, legal;
        acc   = m_load && (m_acc < DEPTH) && in_valid;
        legal = (in_op <= 4'd9);
        @(posedge clk);
        #1;
        m_accepted = acc;
        if (m_we) m_wc++;
        m_we = 0;
        if (!m_load && !m_drain) begin
            if (start) begin
                m_load = 1; m_done = 0; m_acc = 0; m_wc = 0; m_err = 0;
            end
        end else if (m_load) begin
            if (acc && legal) begin
                m_we   = 1;
                m_addr = m_acc;
                m_data = ref_enc(int'(in_op), in_rs, in_rt, in_rd, in_imm);
                m_acc++;
            end else if (acc) begin
                m_err = 1;
            end
            if ((acc && in_last) || (m_acc == DEPTH)) begin
                m_load = 0; m_drain = 1;
            end
        end else begin
            m_drain = 0; m_done = 1;
        end
        if (im_we) wr_log.push_back('{int'(im_addr), im_wdata});
        check_outs();
    endtask

    task automatic run_idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic pulse_start();
        start = 1;
        cycle();
        start = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        model_reset();
        check("rst_im_addr", im_addr, 0);
        check("rst_im_wdata", im_wdata, 0);
        check_outs();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic send(input int op, input int rs, input int rt, input int rd,
                        input int imm, input bit last);
        int n;
        in_op = 4'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_imm = 26'(imm); in_last = last; in_valid = 1;
        n = 0;
        do begin
            cycle();
            start = 0;
            n++;
        end while (!m_accepted && n < 20);
        if (!m_accepted) check("send_timeout", 0, 1);
        in_valid = 0;
        in_last  = 0;
    endtask

    task automatic check_log(input int idx, input int addr, input logic [31:0] data,
                             input bit chk_data);
        if (idx < wr_log.size()) begin
            check($sformatf("log%0d_addr", idx), wr_log[idx].addr, addr);
            if (chk_data) check($sformatf("log%0d_data", idx), wr_log[idx].data, data);
        end else begin
            check($sformatf("log%0d_present", idx), 0, 1);
        end
    endtask

    initial begin
        rst_n = 0; start = 0; in_valid = 0; in_last = 0;
        in_op = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_imm = 0;
        model_reset();
        do_reset();

        // addu with start+valid in the same IDLE cycle; garbage in unused imm
        wr_log.delete();
        start = 1;
        send(0, 1, 2, 3, 26'h3FFFFFF, 1);
        run_idle(3);
        check_log(0, 0, 32'h00221821, 1);
        check("t1_wcnt", word_cnt, 1);
        check("t1_done", done, 1);

        // ori / lui / j / jr with junk in fields the ops ignore
        wr_log.delete();
        pulse_start();
        send(2, 0, 8, 31, 26'h3FF1234, 0);
        send(6, 31, 9, 17, 26'h2AAABCD, 0);
        send(7, 5, 6, 7, 26'h0000C00, 0);
        send(9, 31, 7, 9, 26'h3FFFFFF, 1);
        run_idle(3);
        check_log(0, 0, 32'h34081234, 1);
        check_log(1, 1, 32'h3C09ABCD, 1);
        check_log(2, 2, 32'h08000C00, 1);
        check_log(3, 3, 32'h03E00008, 1);
        check("t2_wcnt", word_cnt, 4);
        check("t2_done", done, 1);

        // capacity: continuous valid, never last
        wr_log.delete();
        pulse_start();
        in_valid = 1;
        for (int i = 0; i < 8; i++) begin
            in_op = 4'($urandom_range(0, 9));
            in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
            in_imm = 26'($urandom);
            cycle();
        end
        in_valid = 0;
        check("t3_nwrites", wr_log.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) check_log(i, i, 32'h0, 0);
        check("t3_ready", in_ready, 0);
        check("t3_done", done, 1);
        check("t3_wcnt", word_cnt, DEPTH);

        // illegal op in the middle
        wr_log.delete();
        pulse_start();
        send(0, 1, 2, 3, 0, 0);
        send(12, 4, 5, 6, 26'h1234, 0);
        send(1, 4, 5, 6, 0, 1);
        run_idle(3);
        check("t4_nwrites", wr_log.size(), 2);
        check_log(0, 0, 32'h00221821, 1);
        check_log(1, 1, 32'h00853023, 1);
        check("t4_err", err, 1);
        pulse_start();
        check("t4_err_clr", err, 0);
        in_valid = 0;
        run_idle(1);

        // reset while a write is on the bus
        do_reset();
        pulse_start();
        send(3, 2, 3, 0, 16'h0010, 0);
        check("t5_we_before", im_we, 1);
        do_reset();
        check("t5_we_after", im_we, 0);
        wr_log.delete();
        pulse_start();
        send(4, 2, 3, 0, 16'h0020, 1);
        run_idle(2);
        check_log(0, 0, ref_enc(4, 2, 3, 0, 16'h0020), 1);

        // start while busy is ignored
        wr_log.delete();
        pulse_start();
        send(5, 1, 1, 0, 16'hFFFE, 0);
        start = 1;
        send(2, 1, 1, 0, 16'h0001, 0);
        start = 1;
        send(8, 0, 0, 0, 26'h1ABCDEF, 1);
        start = 1;
        cycle();
        start = 0;
        run_idle(2);
        check("t6_nwrites", wr_log.size(), 3);
        check_log(0, 0, 32'h1021FFFE, 1);
        check_log(1, 1, 32'h34210001, 1);
        check_log(2, 2, 32'h0DABCDEF, 1);

        // randomized sessions
        for (int s = 0; s < 40; s++) begin
            int n;
            pulse_start();
            n = 0;
            while (!m_done && n < 60) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_op    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                       : 4'($urandom_range(0, 9));
                in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
                in_imm  = 26'($urandom);
                in_last = ($urandom_range(0, 7) == 0);
                start   = ($urandom_range(0, 9) == 0);
                cycle();
                n++;
            end
            in_valid = 0; in_last = 0; start = 0;
            check("rand_done", done, 1);
            run_idle($urandom_range(0, 2));
            if (s == 20) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
